// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - issue controller sequencing decoded ops onto the ALU lanes and data port
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_kind,
    input  logic [3:0]  op_f,
    input  logic [2:0]  op_a,
    input  logic [2:0]  op_b,
    input  logic [2:0]  op_d,
    input  logic [15:0] op_imm,
    input  logic        op_sel,
    input  logic        op_flags,
    input  logic        op_carry,
    output logic [3:0]  alu_f,
    output logic [2:0]  a_idx,
    output logic [2:0]  b_idx,
    output logic [2:0]  d_idx,
    output logic        sel_inp,
    output logic [15:0] t16,
    output logic        carry_mask,
    output logic        wr_reg,
    output logic        wr_flags,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        done
);

    localparam logic [1:0] KIND_REG   = 2'b00;
    localparam logic [1:0] KIND_LOAD  = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;
    localparam logic [1:0] KIND_MEMOP = 2'b11;
    localparam logic [3:0] F_LDA      = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  r_kind;
    logic [3:0]  r_f;
    logic [2:0]  r_a;
    logic [2:0]  r_b;
    logic [2:0]  r_d;
    logic [15:0] r_imm;
    logic        r_sel;
    logic        r_flags;
    logic        r_carry;
    logic [15:0] r_data;

    logic        accept;

    assign op_ready = (state == S_IDLE) && !rst;
    assign accept   = op_valid && op_ready;

    // State register, op field latch on accept, and load-data capture on mem_ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            r_kind  <= KIND_REG;
            r_f     <= 4'd0;
            r_a     <= 3'd0;
            r_b     <= 3'd0;
            r_d     <= 3'd0;
            r_imm   <= 16'd0;
            r_sel   <= 1'b0;
            r_flags <= 1'b0;
            r_carry <= 1'b0;
            r_data  <= 16'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                r_kind  <= op_kind;
                r_f     <= op_f;
                r_a     <= op_a;
                r_b     <= op_b;
                r_d     <= op_d;
                r_imm   <= op_imm;
                r_sel   <= op_sel;
                r_flags <= op_flags;
                r_carry <= op_carry;
            end
            if (state == S_MEM && mem_ack && r_kind != KIND_STORE) begin
                r_data <= mem_rdata;
            end
        end
    end

    // Next state and ALU/memory lanes, decoded only from state and latched fields
    always_comb begin
        next_state = state;
        alu_f      = F_LDA;
        a_idx      = 3'd0;
        b_idx      = 3'd0;
        d_idx      = 3'd0;
        sel_inp    = 1'b0;
        t16        = 16'd0;
        carry_mask = 1'b0;
        wr_reg     = 1'b0;
        wr_flags   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (op_kind == KIND_REG) ? S_EXEC : S_MEM;
                end
            end
            S_MEM: begin
                // Address is R[base]+imm computed by the ALU; MEMOP uses op_b as base
                mem_req = 1'b1;
                mem_we  = (r_kind == KIND_STORE);
                a_idx   = (r_kind == KIND_MEMOP) ? r_b : r_a;
                b_idx   = (r_kind == KIND_STORE) ? r_b : 3'd0;
                t16     = r_imm;
                if (mem_ack) begin
                    if (r_kind == KIND_STORE) begin
                        done       = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        next_state = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                wr_reg     = 1'b1;
                wr_flags   = r_flags;
                done       = 1'b1;
                d_idx      = r_d;
                carry_mask = r_carry;
                case (r_kind)
                    KIND_LOAD: begin
                        alu_f = F_LDA;
                        t16   = r_data;
                    end
                    KIND_MEMOP: begin
                        alu_f = r_f;
                        a_idx = r_a;
                        t16   = r_data;
                    end
                    default: begin
                        alu_f   = r_f;
                        a_idx   = r_a;
                        b_idx   = r_b;
                        sel_inp = r_sel;
                        t16     = r_imm;
                    end
                endcase
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Reset suppresses every strobe so a discarded op leaves no trace
        if (rst) begin
            wr_reg   = 1'b0;
            wr_flags = 1'b0;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            done     = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized transaction-level bench for alu_seq
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_kind;
    logic [3:0]  op_f;
    logic [2:0]  op_a;
    logic [2:0]  op_b;
    logic [2:0]  op_d;
    logic [15:0] op_imm;
    logic        op_sel;
    logic        op_flags;
    logic        op_carry;
    logic [3:0]  alu_f;
    logic [2:0]  a_idx;
    logic [2:0]  b_idx;
    logic [2:0]  d_idx;
    logic        sel_inp;
    logic [15:0] t16;
    logic        carry_mask;
    logic        wr_reg;
    logic        wr_flags;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_kind(op_kind), .op_f(op_f),
        .op_a(op_a), .op_b(op_b), .op_d(op_d),
        .op_imm(op_imm), .op_sel(op_sel), .op_flags(op_flags), .op_carry(op_carry),
        .alu_f(alu_f), .a_idx(a_idx), .b_idx(b_idx), .d_idx(d_idx),
        .sel_inp(sel_inp), .t16(t16), .carry_mask(carry_mask),
        .wr_reg(wr_reg), .wr_flags(wr_flags),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle layout: f[36:33] a[32:30] b[29:27] d[26:24] sel[23] t16[22:7]
    // carry[6] wr_reg[5] wr_flags[4] mem_req[3] mem_we[2] done[1] op_ready[0]
    localparam logic [36:0] M_ALL   = {37{1'b1}};
    localparam logic [36:0] M_F     = 37'hF << 33;
    localparam logic [36:0] M_A     = 37'h7 << 30;
    localparam logic [36:0] M_B     = 37'h7 << 27;
    localparam logic [36:0] M_D     = 37'h7 << 24;
    localparam logic [36:0] M_SEL   = 37'h1 << 23;
    localparam logic [36:0] M_CARRY = 37'h1 << 6;
    localparam logic [36:0] M_STRB  = 37'h3F;

    logic [36:0] got;
    assign got = {alu_f, a_idx, b_idx, d_idx, sel_inp, t16, carry_mask,
                  wr_reg, wr_flags, mem_req, mem_we, done, op_ready};

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] mk(input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] d, input logic sel, input logic [15:0] t,
                                       input logic c, input logic wr, input logic wf, input logic rq,
                                       input logic we, input logic dn, input logic rdy);
        return {f, a, b, d, sel, t, c, wr, wf, rq, we, dn, rdy};
    endfunction

    function automatic logic [36:0] idle_exp();
        return mk(4'b0111, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive unrelated op fields so the bench sees the DUT ignore them outside IDLE
    task automatic junk_op();
        op_valid = 1'b1;
        op_kind  = 2'($urandom);
        op_f     = 4'($urandom);
        op_a     = 3'($urandom);
        op_b     = 3'($urandom);
        op_d     = 3'($urandom);
        op_imm   = 16'($urandom);
        op_sel   = 1'($urandom);
        op_flags = 1'($urandom);
        op_carry = 1'($urandom);
    endtask

    // One complete transaction: present in IDLE, k wait cycles in MEM, optional reset
    // at MEM cycle rst_at (-1 for none), then expected EXEC or STORE retirement.
    task automatic run_op(input logic [1:0] kind, input logic [3:0] f, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] d, input logic [15:0] imm,
                          input logic sel, input logic flags, input logic carry,
                          input logic [15:0] rdata, input int k, input int rst_at);
        logic        is_store;
        logic        is_memop;
        logic [36:0] m;
        is_store = (kind == 2'b10);
        is_memop = (kind == 2'b11);

        op_valid = 1'b1;
        op_kind  = kind;
        op_f     = f;
        op_a     = a;
        op_b     = b;
        op_d     = d;
        op_imm   = imm;
        op_sel   = sel;
        op_flags = flags;
        op_carry = carry;
        mem_ack  = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        check("accept", got, idle_exp());
        cyc();
        junk_op();
        mem_ack = 1'b0;

        if (kind == 2'b00) begin
            #1;
            check("exec_reg", got, mk(f, a, b, d, sel, imm, carry, 1'b1, flags, 1'b0, 1'b0, 1'b1, 1'b0));
            cyc();
            return;
        end

        for (int i = 0; i <= k; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                mem_ack = 1'b0;
                #1;
                check("rst_strobes", got & M_STRB, 37'd0);
                cyc();
                rst = 1'b0;
                mem_ack = 1'b1;
                mem_rdata = 16'($urandom);
                op_valid = 1'b0;
                #1;
                check("post_rst_idle", got, idle_exp());
                cyc();
                mem_ack = 1'b0;
                #1;
                check("post_rst_hold", got, idle_exp());
                return;
            end
            mem_ack   = (i == k);
            mem_rdata = (i == k) ? rdata : 16'($urandom);
            m = M_ALL & ~(M_F | M_D | M_SEL | M_CARRY);
            #1;
            check("mem", got & m,
                  mk(4'd0, is_memop ? b : a, is_store ? b : 3'd0, 3'd0, 1'b0, imm, 1'b0,
                     1'b0, 1'b0, 1'b1, is_store, is_store && (i == k), 1'b0) & m);
            cyc();
        end
        mem_ack = 1'b0;
        if (is_store) return;

        if (is_memop) begin
            m = M_ALL & ~M_B;
            #1;
            check("exec_memop", got & m,
                  mk(f, a, 3'd0, d, 1'b0, rdata, carry, 1'b1, flags, 1'b0, 1'b0, 1'b1, 1'b0) & m);
        end else begin
            m = M_ALL & ~(M_A | M_B);
            #1;
            check("exec_load", got & m,
                  mk(4'b0111, 3'd0, 3'd0, d, 1'b0, rdata, carry, 1'b1, flags, 1'b0, 1'b0, 1'b1, 1'b0) & m);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        op_valid = 1'b0;
        op_kind = 2'b00; op_f = 4'd0; op_a = 3'd0; op_b = 3'd0; op_d = 3'd0;
        op_imm = 16'd0; op_sel = 1'b0; op_flags = 1'b0; op_carry = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 16'd0;
        cyc();
        cyc();
        check("reset_strobes", got & M_STRB, 37'd0);
        rst = 1'b0;
        #1;
        check("reset_idle", got, idle_exp());
        cyc();

        // Directed cases from the intended usage
        run_op(2'b00, 4'b0000, 3'd1, 3'd2, 3'd4, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 0, -1);
        run_op(2'b01, 4'b0000, 3'd1, 3'd0, 3'd5, 16'h0004, 1'b0, 1'b0, 1'b0, 16'hBEEF, 3, -1);
        run_op(2'b10, 4'b0000, 3'd1, 3'd6, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, -1);
        run_op(2'b11, 4'b0010, 3'd3, 3'd2, 3'd7, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0003, 2, -1);
        run_op(2'b01, 4'b0000, 3'd1, 3'd0, 3'd5, 16'h0004, 1'b0, 1'b0, 1'b0, 16'hBEEF, 3, 2);

        // Stray ack while idle must not start anything
        op_valid = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("stray_ack", got, idle_exp());
        cyc();
        mem_ack = 1'b0;
        #1;
        check("stray_ack_after", got, idle_exp());

        for (int n = 0; n < 200; n++) begin
            int k;
            int ra;
            k  = int'($urandom_range(0, 4));
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, k)) : -1;
            run_op(2'($urandom), 4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), k, ra);
            if ($urandom_range(0, 3) == 0) begin
                op_valid = 1'b0;
                mem_ack = 1'($urandom);
                #1;
                check("gap_idle", got, idle_exp());
                cyc();
                mem_ack = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
